// File: rtl/power_emu_seq.sv
// rtl/power_emu_seq.sv - run sequencer between the emulator register file and the compute core
// Turns a level start bit into a one-cycle core launch, supervises the run and captures the result.
module power_emu_seq #(
    parameter int BITS    = 32,
    parameter int CGES    = 13,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_start,
    input  logic             cmd_clear,
    output logic             core_start,
    input  logic             core_done,
    input  logic [BITS+3:0]  core_result,
    output logic [31:0]      res_hi,
    output logic [31:0]      res_lo,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic             irq,
    output logic [31:0]      cycle_count
);

    if (BITS + 4 > 64 || TIMEOUT < 2 || CGES < 1) begin : g_param_check
        $error("power_emu_seq: unsupported parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        start_q;
    logic        core_start_q, core_start_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic        irq_q, irq_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic [31:0] count_q, count_d;

    logic        start_edge;
    logic        timeout_hit;
    logic [63:0] result_ext;

    assign start_edge  = cmd_start & ~start_q;
    assign timeout_hit = (count_q == 32'(TIMEOUT - 1));
    assign result_ext  = 64'(core_result);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            irq_q        <= 1'b0;
            res_hi_q     <= '0;
            res_lo_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= cmd_start;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            irq_q        <= irq_d;
            res_hi_q     <= res_hi_d;
            res_lo_q     <= res_lo_d;
            count_q      <= count_d;
        end
    end

    // Clear always outranks everything else, including a simultaneous start edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_edge && !cmd_clear) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (cmd_clear)        state_d = S_IDLE;
                else if (core_done)   state_d = S_DONE;
                else if (timeout_hit) state_d = S_DONE;
            end
            S_DONE: begin
                if (cmd_clear)       state_d = S_IDLE;
                else if (start_edge) state_d = S_LAUNCH;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are derived from the next state so every port comes straight from a flop.
    always_comb begin
        core_start_d = (state_d == S_LAUNCH);
        busy_d       = (state_d == S_LAUNCH) || (state_d == S_WAIT);
        done_d       = (state_d == S_DONE);
        irq_d        = (state_d == S_DONE) && (state_q != S_DONE);
        timeout_d    = timeout_q;
        res_hi_d     = res_hi_q;
        res_lo_d     = res_lo_q;
        count_d      = count_q;

        if (state_d != S_DONE) begin
            timeout_d = 1'b0;
        end else if (state_q == S_WAIT) begin
            timeout_d = ~core_done;
        end

        if (state_q == S_WAIT && state_d == S_DONE && core_done) begin
            res_hi_d = result_ext[63:32];
            res_lo_d = result_ext[31:0];
        end

        if (state_d == S_LAUNCH) begin
            count_d = '0;
        end else if (state_q == S_WAIT && count_q != 32'hFFFF_FFFF) begin
            count_d = count_q + 32'd1;
        end
    end

    assign core_start  = core_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_q;
    assign irq         = irq_q;
    assign res_hi      = res_hi_q;
    assign res_lo      = res_lo_q;
    assign cycle_count = count_q;

endmodule

// File: doc/power_emu_seq.md
Name: power_emu_seq

Overview:
Run sequencer between the power-emulator Avalon register file and the TOP compute core.
- Converts the level start bit from the register file into a single-cycle core launch.
- Supervises the run with a cycle counter and a timeout.
- Captures the (BITS+4)-bit core result into two 32-bit words for host readback.
- Exposes busy/done/timeout status and a one-cycle interrupt.

Parameters:
BITS, 32, core accuracy; result width RW = BITS+4; RW must be ≤ 64.
CGES, 13, core stage count; passed through for documentation only, no logic depends on it.
TIMEOUT, 1024, maximum WAIT cycles before a run is aborted; must be ≥ 2.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
cmd_start  in  1  level start bit from register file; a rising edge requests a run
cmd_clear  in  1  level clear/abort request, sampled every cycle
core_start  out  1  one-cycle launch pulse to core
core_done  in  1  core completion strobe; result valid in the same cycle
core_result  in  RW  core result
res_hi  out  32  result[RW-1:32], zero-extended; 0 when RW ≤ 32
res_lo  out  32  result[31:0], zero-extended when RW < 32
busy  out  1  high in LAUNCH and WAIT
done  out  1  sticky completion flag
timeout_err  out  1  sticky; last run ended by timeout
irq  out  1  one-cycle pulse on entry to DONE
cycle_count  out  32  WAIT cycles of the current or last run

Behaviour:
- Reset is synchronous on reset_n low. It forces:
  - state IDLE;
  - core_start, busy, done, timeout_err, irq = 0;
  - res_hi, res_lo, cycle_count = 0;
  - start_q = 0.
- start_q registers cmd_start every cycle. A start edge is cmd_start & ~start_q.
- State IDLE:
  - A start edge with cmd_clear low moves to LAUNCH.
- State LAUNCH (exactly 1 cycle):
  - core_start = 1; cycle_count cleared to 0; done and timeout_err cleared.
  - Always moves to WAIT.
- State WAIT: cycle_count increments by 1 each cycle. Checks are evaluated in this priority order:
  1. cmd_clear = 1: go to IDLE. This is an abort: no irq, results unchanged, done stays 0.
  2. core_done = 1: register res_hi/res_lo from core_result, go to DONE.
  3. cycle_count = TIMEOUT-1: set timeout_err, go to DONE, results unchanged.
  - If core_done and the timeout threshold occur in the same cycle, done wins and timeout_err stays 0.
- State DONE:
  - done = 1; irq = 1 on the first DONE cycle only.
  - cmd_clear = 1: go to IDLE; done and timeout_err cleared; res_hi, res_lo, cycle_count retained.
  - Start edge (clear low): go directly to LAUNCH.
  - Start edge and cmd_clear in the same cycle: clear wins and the edge is consumed. Host must toggle cmd_start again.
- Ignored events:
  - Start edges in LAUNCH or WAIT.
  - core_done in IDLE, LAUNCH or DONE.
- Latency:
  - Start edge sampled at edge N → core_start high in cycle N+1 → WAIT from N+2.
  - core_done sampled at edge M → results and done valid, irq high, in cycle M+1.
- cycle_count is the number of WAIT cycles up to and including the cycle in which core_done was sampled. It saturates at 2^32-1 (unreachable while TIMEOUT < 2^32).
- All outputs are registered. No combinational path from any input to any output.
- Reset asserted mid-run returns to IDLE with all outputs at reset values. core_start is never left high.

Test Plan:
1. Basic run (BITS=32, RW=36): raise cmd_start; core_done after 5 WAIT cycles with core_result = 36'hA_1234_5678 → single core_start pulse; res_hi = 0x0000000A, res_lo = 0x12345678, cycle_count = 5, irq one cycle, done = 1, busy = 0.
2. Timeout (TIMEOUT=16), core_done never asserted → DONE after exactly 16 WAIT cycles; timeout_err = 1, cycle_count = 16, res_hi/res_lo keep prior values, irq pulses once.
3. Abort: cmd_clear in WAIT cycle 3 → IDLE next cycle; no irq, done = 0, busy = 0. A later start edge launches normally.
4. Edge rules:
   - cmd_start held high across two runs → only one launch.
   - A start edge during WAIT → ignored.
   - A start edge in DONE → new LAUNCH, done cleared.
   - Start edge and cmd_clear together in DONE → IDLE, no launch.
5. Race (TIMEOUT=8): core_done in the 8th WAIT cycle → result captured, timeout_err = 0.
6. Narrow width (BITS=20, RW=24): core_result = 24'hFEDCBA → res_lo = 0x00FEDCBA, res_hi = 0. Then reset_n low mid-WAIT → all outputs 0 on the next edge.
